// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out framed transmitter.
// Accepts a WIDTH-bit word on a load/ready handshake and sends it as
// start bit (0), data bits LSB first, stop bit (1); each bit lasts DIV clocks.
//
// Parameters:
//   WIDTH  data bits per frame (>=1)
//   DIV    clock cycles per serial bit (>=1)
// Ports:
//   clk    rising-edge clock
//   clr    synchronous active-high reset
//   d      parallel word, sampled only when a load is accepted
//   load   request to send d; accepted when ready=1
//   ready  high when idle and able to accept load (registered)
//   sout   serial line, idles high (registered)
//   done   one-cycle pulse after the stop bit of each frame (registered)

module piso_tx #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             done
);

    localparam int unsigned DIV_CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_CW = $clog2(WIDTH + 1);

    localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [DIV_CW-1:0] r_div_cnt;
    logic [BIT_CW-1:0] r_bit_cnt;
    logic [WIDTH-1:0]  r_shift;
    logic              r_sout;
    logic              r_ready;
    logic              r_done;

    // Last clock of the current serial bit period.
    logic              w_bit_end;
    // Shift register contents after the next shift; bit 0 is the next data bit.
    logic [WIDTH-1:0]  w_shift_nxt;

    assign w_bit_end   = (r_div_cnt == DIV_LAST);
    assign w_shift_nxt = r_shift >> 1;

    assign ready = r_ready;
    assign sout  = r_sout;
    assign done  = r_done;

    // Frame sequencer; sout/ready/done are updated together with the state so
    // they always reflect the bit currently on the line.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_sout    <= 1'b1;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shift   <= d;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= START;
                        r_ready   <= 1'b0;
                        r_sout    <= 1'b0;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_div_cnt <= '0;
                        r_state   <= DATA;
                        r_sout    <= r_shift[0];
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_CW'(1);
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        r_div_cnt <= '0;
                        r_shift   <= w_shift_nxt;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= STOP;
                            r_sout    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_CW'(1);
                            r_sout    <= w_shift_nxt[0];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_CW'(1);
                    end
                end

                STOP: begin
                    if (w_bit_end) begin
                        // Returning to IDLE raises ready in the same cycle as done,
                        // so a held load starts the next frame right after it.
                        r_div_cnt <= '0;
                        r_state   <= IDLE;
                        r_ready   <= 1'b1;
                        r_done    <= 1'b1;
                        r_sout    <= 1'b1;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_CW'(1);
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                    r_sout    <= 1'b1;
                    r_ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
